twiddle_multiplier: RTL and testbench

//  Consumer end of the twiddle interface (br, bi, mux_selection, Multiplier_Enable) of the 16-point radix-2^2 FFT.

---
 rtl/fft16_pkg.sv | 21 ++
 rtl/twiddle_multiplier_cmul_core.sv | 50 +++++
 rtl/twiddle_multiplier.sv | 95 +++++++++
 tb/tb_twiddle_multiplier.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fft16_pkg.sv
// Shared constants for the 16-point radix-2^2 FFT: data/twiddle widths, rounding bias
// and the Q4.11 twiddle factors W^k = exp(-j*2*pi*k/16) for k = 1..9.
package fft16_pkg;

    localparam int unsigned FFT_WIDTH  = 16;
    localparam int unsigned FFT_FRAC   = 11;
    localparam int unsigned ROUND_BIAS = 1 << (FFT_FRAC - 1);

    typedef logic signed [FFT_WIDTH-1:0] tw_t;

    localparam tw_t W1_R =  16'sd1892;  localparam tw_t W1_I = -16'sd784;
    localparam tw_t W2_R =  16'sd1448;  localparam tw_t W2_I = -16'sd1448;
    localparam tw_t W3_R =  16'sd784;   localparam tw_t W3_I = -16'sd1892;
    localparam tw_t W4_R =  16'sd0;     localparam tw_t W4_I = -16'sd2048;
    localparam tw_t W5_R = -16'sd784;   localparam tw_t W5_I = -16'sd1892;
    localparam tw_t W6_R = -16'sd1448;  localparam tw_t W6_I = -16'sd1448;
    localparam tw_t W7_R = -16'sd1892;  localparam tw_t W7_I = -16'sd784;
    localparam tw_t W8_R = -16'sd2048;  localparam tw_t W8_I =  16'sd0;
    localparam tw_t W9_R = -16'sd1892;  localparam tw_t W9_I =  16'sd784;

endpackage

// File: rtl/twiddle_multiplier_cmul_core.sv
// Final-stage complex-multiply datapath: combine four products, round half up, then
// saturate (TWIDDLE_SAT_EN defined) or wrap to WIDTH bits; bypass passes the sample through.
module twiddle_cmul_core
    import fft16_pkg::*;
#(
    parameter int unsigned WIDTH = FFT_WIDTH,
    parameter int unsigned FRAC  = FFT_FRAC
) (
    input  logic signed [2*WIDTH-1:0] pr_rr,
    input  logic signed [2*WIDTH-1:0] pr_ii,
    input  logic signed [2*WIDTH-1:0] pr_ri,
    input  logic signed [2*WIDTH-1:0] pr_ir,
    input  logic signed [WIDTH-1:0]   byp_r,
    input  logic signed [WIDTH-1:0]   byp_i,
    input  logic                      sel,
    output logic signed [WIDTH-1:0]   yr_c,
    output logic signed [WIDTH-1:0]   yi_c
);

    localparam int unsigned SW = 2 * WIDTH + 1;
    localparam logic signed [SW-1:0] RBIAS = SW'(1) <<< (FRAC - 1);
    localparam logic signed [SW-1:0] MAXV  = SW'((64'd1 << (WIDTH - 1)) - 64'd1);
    localparam logic signed [SW-1:0] MINV  = -MAXV - SW'(1);

    logic signed [SW-1:0] sum_r, sum_i, rnd_r, rnd_i;

    function automatic logic signed [WIDTH-1:0] limit(input logic signed [SW-1:0] v);
`ifdef TWIDDLE_SAT_EN
        if (v > MAXV)      return WIDTH'(MAXV);
        else if (v < MINV) return WIDTH'(MINV);
        else               return WIDTH'(v);
`else
        return WIDTH'(v);
`endif
    endfunction

    always_comb begin
        sum_r = SW'(pr_rr) - SW'(pr_ii);
        sum_i = SW'(pr_ri) + SW'(pr_ir);
        rnd_r = (sum_r + RBIAS) >>> FRAC;
        rnd_i = (sum_i + RBIAS) >>> FRAC;
        yr_c  = byp_r;
        yi_c  = byp_i;
        if (sel) begin
            yr_c = limit(rnd_r);
            yi_c = limit(rnd_i);
        end
    end

endmodule

// File: rtl/twiddle_multiplier.sv
// Three-stage twiddle multiplier (register inputs, products, round/limit) with ready/valid
// backpressure; TWIDDLE_SAT_EN selects saturating instead of wrapping results.
module twiddle_multiplier
    import fft16_pkg::*;
#(
    parameter int unsigned WIDTH = FFT_WIDTH,
    parameter int unsigned FRAC  = FFT_FRAC
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] ar,
    input  logic signed [WIDTH-1:0] ai,
    input  logic signed [WIDTH-1:0] br,
    input  logic signed [WIDTH-1:0] bi,
    input  logic                    mux_selection,
    output logic                    Multiplier_Enable,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] yr,
    output logic signed [WIDTH-1:0] yi
);

    localparam int unsigned PW = 2 * WIDTH;

    logic                    advance;
    logic                    s1_valid, s1_sel;
    logic signed [WIDTH-1:0] s1_ar, s1_ai, s1_br, s1_bi;
    logic                    s2_valid, s2_sel;
    logic signed [WIDTH-1:0] s2_ar, s2_ai;
    logic signed [PW-1:0]    s2_rr, s2_ii, s2_ri, s2_ir;
    logic signed [WIDTH-1:0] cm_yr, cm_yi;

    // Whole pipeline moves as one; a stalled output freezes every stage.
    assign advance           = !out_valid || out_ready;
    assign in_ready          = rst || advance;
    assign Multiplier_Enable = in_valid && advance && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_sel    <= 1'b0;
            s1_ar     <= '0;
            s1_ai     <= '0;
            s1_br     <= '0;
            s1_bi     <= '0;
            s2_valid  <= 1'b0;
            s2_sel    <= 1'b0;
            s2_ar     <= '0;
            s2_ai     <= '0;
            s2_rr     <= '0;
            s2_ii     <= '0;
            s2_ri     <= '0;
            s2_ir     <= '0;
            out_valid <= 1'b0;
            yr        <= '0;
            yi        <= '0;
        end else if (advance) begin
            s1_valid  <= in_valid;
            s1_sel    <= mux_selection;
            s1_ar     <= ar;
            s1_ai     <= ai;
            s1_br     <= br;
            s1_bi     <= bi;
            s2_valid  <= s1_valid;
            s2_sel    <= s1_sel;
            s2_ar     <= s1_ar;
            s2_ai     <= s1_ai;
            s2_rr     <= PW'(s1_ar) * PW'(s1_br);
            s2_ii     <= PW'(s1_ai) * PW'(s1_bi);
            s2_ri     <= PW'(s1_ar) * PW'(s1_bi);
            s2_ir     <= PW'(s1_ai) * PW'(s1_br);
            out_valid <= s2_valid;
            yr        <= cm_yr;
            yi        <= cm_yi;
        end
    end

    twiddle_cmul_core #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_core (
        .pr_rr (s2_rr),
        .pr_ii (s2_ii),
        .pr_ri (s2_ri),
        .pr_ir (s2_ir),
        .byp_r (s2_ar),
        .byp_i (s2_ai),
        .sel   (s2_sel),
        .yr_c  (cm_yr),
        .yi_c  (cm_yi)
    );

endmodule

// File: tb/tb_twiddle_multiplier.sv
// Directed + scoreboard bench for twiddle_multiplier; expected {yr,yi} queued at acceptance.
module tb_twiddle_multiplier;
    import fft16_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] ar, ai, br, bi;
    logic        mux_selection;
    logic        Multiplier_Enable;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] yr, yi;

    int          checks = 0;
    int          errors = 0;
    int          me_count = 0;
    int          stall_count = 0;
    int          out_count = 0;
    logic [31:0] sb[$];
    logic [31:0] mon_exp;
    tw_t         tw_r[10];
    tw_t         tw_i[10];

    twiddle_multiplier dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .ar                (ar),
        .ai                (ai),
        .br                (br),
        .bi                (bi),
        .mux_selection     (mux_selection),
        .Multiplier_Enable (Multiplier_Enable),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .yr                (yr),
        .yi                (yi)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lim(input longint v);
`ifdef TWIDDLE_SAT_EN
        if (v > 32767)       return 16'h7FFF;
        else if (v < -32768) return 16'h8000;
`endif
        return 16'(v);
    endfunction

    function automatic logic [31:0] model(input logic signed [15:0] a, input logic signed [15:0] b,
                                          input logic signed [15:0] c, input logic signed [15:0] d,
                                          input logic sel);
        longint re, im;
        if (!sel) return {a, b};
        re = (longint'(a) * longint'(c) - longint'(b) * longint'(d) + longint'(ROUND_BIAS)) >>> FFT_FRAC;
        im = (longint'(a) * longint'(d) + longint'(b) * longint'(c) + longint'(ROUND_BIAS)) >>> FFT_FRAC;
        return {lim(re), lim(im)};
    endfunction

    // Output monitor: every transfer must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (Multiplier_Enable) me_count++;
            if (!in_ready) stall_count++;
            if (out_valid && out_ready) begin
                out_count++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL unexpected_output: observed %h_%h expected none", yr, yi);
                end else begin
                    mon_exp = sb.pop_front();
                    check("output", {yr, yi}, mon_exp);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                        input logic [15:0] d, input logic sel, input logic [31:0] e);
        ar = a; ai = b; br = c; bi = d; mux_selection = sel; in_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                @(posedge clk);
                #1;
                return;
            end
        end
        check("send_timeout", 32'd1, 32'd0);
    endtask

    task automatic latency_check(input string tag);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check(tag, 32'(out_valid), 32'(c == 3));
        end
        step(1);
    endtask

    task automatic drain();
        for (int n = 0; n < 200 && sb.size() != 0; n++) @(negedge clk);
        check("drain", 32'(sb.size()), 32'd0);
        step(1);
    endtask

    initial begin
        int cnt_before;
        logic [15:0] ra, rb, twr, twi;
        logic        rs;

        tw_r = '{16'sd2048, W1_R, W2_R, W3_R, W4_R, W5_R, W6_R, W7_R, W8_R, W9_R};
        tw_i = '{16'sd0,    W1_I, W2_I, W3_I, W4_I, W5_I, W6_I, W7_I, W8_I, W9_I};

        // Reset: sample offered during reset must not be taken.
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        ar = 16'h1111; ai = 16'h2222; br = 16'h0800; bi = 16'h0; mux_selection = 1'b1;
        step(2);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_yr_yi", {yr, yi}, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_me", 32'(Multiplier_Enable), 32'd0);
        step(1);
        rst = 1'b0; in_valid = 1'b0;
        step(1);

        // 1: bypass with generator filler twiddle, 3-cycle latency, single-cycle valid.
        send(16'h1234, 16'hFEDC, 16'h0001, 16'h0001, 1'b0, {16'h1234, 16'hFEDC});
        in_valid = 1'b0;
        latency_check("t1_latency");
        drain();

        // 2..4: -j, W2, and the overflow corner, back to back.
        send(16'h0400, 16'h0000, 16'h0000, 16'hF800, 1'b1, {16'h0000, 16'hFC00});
        send(16'h0800, 16'h0000, 16'h05A8, 16'hFA58, 1'b1, {16'h05A8, 16'hFA58});
`ifdef TWIDDLE_SAT_EN
        send(16'h8000, 16'h0000, 16'h0000, 16'hF800, 1'b1, {16'h0000, 16'h7FFF});
`else
        send(16'h8000, 16'h0000, 16'h0000, 16'hF800, 1'b1, {16'h0000, 16'h8000});
`endif
        in_valid = 1'b0;
        drain();

        // 5: 16-sample stream with a 5-cycle output stall.
        me_count = 0; stall_count = 0; out_count = 0;
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    ra = 16'($urandom); rb = 16'($urandom);
                    rs = (i % 4) != 3;
                    twr = rs ? 16'(tw_r[i % 10]) : 16'h0001;
                    twi = rs ? 16'(tw_i[i % 10]) : 16'h0001;
                    send(ra, rb, twr, twi, rs, model(ra, rb, twr, twi, rs));
                end
                in_valid = 1'b0;
            end
            begin
                step(6);
                out_ready = 1'b0;
                step(5);
                out_ready = 1'b1;
            end
        join
        drain();
        check("t5_me_pulses", 32'(me_count), 32'd16);
        check("t5_stall_cycles", 32'(stall_count), 32'd5);
        check("t5_outputs", 32'(out_count), 32'd16);

        // 6: reset with two samples in flight.
        send(16'h0100, 16'h0200, 16'h0800, 16'h0000, 1'b1, 32'h0);
        send(16'h0300, 16'h0400, 16'h0000, 16'h0000, 1'b0, 32'h0);
        rst = 1'b1; sb.delete();
        ar = 16'h5555; ai = 16'h6666; mux_selection = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        check("t6_rst_in_ready", 32'(in_ready), 32'd1);
        check("t6_rst_me", 32'(Multiplier_Enable), 32'd0);
        step(1);
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("t6_out_valid", 32'(out_valid), 32'd0);
        check("t6_yr_yi", {yr, yi}, 32'd0);
        cnt_before = out_count;
        step(5);
        check("t6_no_stale", 32'(out_count), 32'(cnt_before));
        send(16'h0400, 16'h0000, 16'h0000, 16'hF800, 1'b1, {16'h0000, 16'hFC00});
        in_valid = 1'b0;
        latency_check("t6_latency");
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
